// File: rtl/de_bus_arbiter.sv
// Two-port round-robin arbiter for the display-engine frame-store bus, with bounded bursts.
// Optional per-port ack counters are compiled in when DE_ARB_STATS_EN is defined.
module de_bus_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_de_req,
  output logic              m0_de_ack,
  input  logic [ADDR_W-1:0] m0_de_addr,
  input  logic [3:0]        m0_de_nbyte,
  input  logic              m0_de_rnw,
  input  logic [31:0]       m0_de_w_data,
  output logic [31:0]       m0_de_r_data,
  input  logic              m1_de_req,
  output logic              m1_de_ack,
  input  logic [ADDR_W-1:0] m1_de_addr,
  input  logic [3:0]        m1_de_nbyte,
  input  logic              m1_de_rnw,
  input  logic [31:0]       m1_de_w_data,
  output logic [31:0]       m1_de_r_data,
  output logic              de_req,
  input  logic              de_ack,
  output logic [ADDR_W-1:0] de_addr,
  output logic [3:0]        de_nbyte,
  output logic              de_rnw,
  output logic [31:0]       de_w_data,
  input  logic [31:0]       de_r_data,
  output logic              busy
`ifdef DE_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat0,
  output logic [15:0]       stat1
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic gnt0, gnt1;
  logic own, own_req, oth_req;
  state_t oth_state;

  assign gnt0      = (state_reg == GNT0);
  assign gnt1      = (state_reg == GNT1);
  assign own       = gnt1;
  assign own_req   = own ? m1_de_req : m0_de_req;
  assign oth_req   = own ? m0_de_req : m1_de_req;
  assign oth_state = own ? GNT0 : GNT1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (m0_de_req && m1_de_req) state_next = last_reg ? GNT0 : GNT1;
        else if (m0_de_req)         state_next = GNT0;
        else if (m1_de_req)         state_next = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_req) begin
          // Owner released the bus: hand over or fall idle.
          last_next  = own;
          cnt_next   = '0;
          state_next = oth_req ? oth_state : IDLE;
        end else if (de_ack) begin
          if (oth_req && (cnt_reg == LAST_CNT)) begin
            last_next  = own;
            cnt_next   = '0;
            state_next = oth_state;
          end else if (cnt_reg != LAST_CNT) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave-side mux: idle presents a harmless all-lanes-disabled read of word 0.
  always_comb begin
    de_req    = (gnt0 & m0_de_req) | (gnt1 & m1_de_req);
    de_addr   = '0;
    de_nbyte  = 4'hF;
    de_rnw    = 1'b1;
    de_w_data = '0;
    if (gnt0) begin
      de_addr   = m0_de_addr;
      de_nbyte  = m0_de_nbyte;
      de_rnw    = m0_de_rnw;
      de_w_data = m0_de_w_data;
    end else if (gnt1) begin
      de_addr   = m1_de_addr;
      de_nbyte  = m1_de_nbyte;
      de_rnw    = m1_de_rnw;
      de_w_data = m1_de_w_data;
    end
  end

  assign m0_de_ack    = de_ack & gnt0;
  assign m1_de_ack    = de_ack & gnt1;
  assign m0_de_r_data = de_r_data;
  assign m1_de_r_data = de_r_data;
  assign busy         = (state_reg != IDLE);

`ifdef DE_ARB_STATS_EN
  logic [15:0] stat0_reg, stat1_reg;

  // Clear has priority over a coincident ack.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat0_reg <= '0;
      stat1_reg <= '0;
    end else begin
      if (m0_de_ack) stat0_reg <= stat0_reg + 16'd1;
      if (m1_de_ack) stat1_reg <= stat1_reg + 16'd1;
    end
  end

  assign stat0 = stat0_reg;
  assign stat1 = stat1_reg;
`endif

endmodule

// File: tb/tb_de_bus_arbiter.sv
// Self-checking bench for de_bus_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transfer-level ownership model.
module tb_de_bus_arbiter;
  localparam int ADDR_W    = 18;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_req   [2];
  logic              m_ack   [2];
  logic [ADDR_W-1:0] m_addr  [2];
  logic [3:0]        m_nbyte [2];
  logic              m_rnw   [2];
  logic [31:0]       m_wdata [2];
  logic [31:0]       m_rdata [2];
  logic              de_req, de_ack, de_rnw, busy;
  logic [ADDR_W-1:0] de_addr;
  logic [3:0]        de_nbyte;
  logic [31:0]       de_w_data, de_r_data;
`ifdef DE_ARB_STATS_EN
  logic              stat_clr;
  logic [15:0]       stat0, stat1;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Model: who owns the bus (-1 none), who was served last, transfers done in this burst.
  int   mdl_owner;
  int   mdl_last;
  int   mdl_served;
  int   mdl_stat [2];
  logic exp_ack  [2];
  logic obs_ack  [2];

  always #5 clk = ~clk;

  de_bus_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .m0_de_req    (m_req[0]),
    .m0_de_ack    (m_ack[0]),
    .m0_de_addr   (m_addr[0]),
    .m0_de_nbyte  (m_nbyte[0]),
    .m0_de_rnw    (m_rnw[0]),
    .m0_de_w_data (m_wdata[0]),
    .m0_de_r_data (m_rdata[0]),
    .m1_de_req    (m_req[1]),
    .m1_de_ack    (m_ack[1]),
    .m1_de_addr   (m_addr[1]),
    .m1_de_nbyte  (m_nbyte[1]),
    .m1_de_rnw    (m_rnw[1]),
    .m1_de_w_data (m_wdata[1]),
    .m1_de_r_data (m_rdata[1]),
    .de_req       (de_req),
    .de_ack       (de_ack),
    .de_addr      (de_addr),
    .de_nbyte     (de_nbyte),
    .de_rnw       (de_rnw),
    .de_w_data    (de_w_data),
    .de_r_data    (de_r_data),
    .busy         (busy)
`ifdef DE_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat0        (stat0),
    .stat1        (stat1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic              e_req, e_rnw;
    logic [ADDR_W-1:0] e_addr;
    logic [3:0]        e_nbyte;
    logic [31:0]       e_wd;
    if (mdl_owner < 0) begin
      e_req = 1'b0; e_addr = '0; e_nbyte = 4'hF; e_rnw = 1'b1; e_wd = '0;
    end else begin
      e_req   = m_req[mdl_owner];
      e_addr  = m_addr[mdl_owner];
      e_nbyte = m_nbyte[mdl_owner];
      e_rnw   = m_rnw[mdl_owner];
      e_wd    = m_wdata[mdl_owner];
    end
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = de_ack && (mdl_owner == i);
      obs_ack[i] = m_ack[i];
    end
    check("de_req",    32'(de_req),    32'(e_req));
    check("de_addr",   32'(de_addr),   32'(e_addr));
    check("de_nbyte",  32'(de_nbyte),  32'(e_nbyte));
    check("de_rnw",    32'(de_rnw),    32'(e_rnw));
    check("de_w_data", de_w_data,      e_wd);
    check("m0_ack",    32'(m_ack[0]),  32'(exp_ack[0]));
    check("m1_ack",    32'(m_ack[1]),  32'(exp_ack[1]));
    check("m0_rdata",  m_rdata[0],     de_r_data);
    check("m1_rdata",  m_rdata[1],     de_r_data);
    check("busy",      32'(busy),      32'(mdl_owner >= 0));
`ifdef DE_ARB_STATS_EN
    check("stat0",     32'(stat0),     32'(mdl_stat[0]));
    check("stat1",     32'(stat1),     32'(mdl_stat[1]));
`endif
  endtask

  task automatic model_update();
    int x, y;
    if (rst) begin
      mdl_owner = -1; mdl_last = 1; mdl_served = 0;
      mdl_stat[0] = 0; mdl_stat[1] = 0;
      return;
    end
    for (int i = 0; i < 2; i++)
      if (exp_ack[i]) mdl_stat[i] = (mdl_stat[i] + 1) % 65536;
`ifdef DE_ARB_STATS_EN
    if (stat_clr) begin mdl_stat[0] = 0; mdl_stat[1] = 0; end
`endif
    if (mdl_owner < 0) begin
      mdl_served = 0;
      if (m_req[0] && m_req[1]) mdl_owner = 1 - mdl_last;
      else if (m_req[0])        mdl_owner = 0;
      else if (m_req[1])        mdl_owner = 1;
    end else begin
      x = mdl_owner; y = 1 - x;
      if (!m_req[x]) begin
        mdl_last = x; mdl_served = 0;
        mdl_owner = m_req[y] ? y : -1;
      end else if (de_ack) begin
        if (m_req[y] && mdl_served + 1 >= MAX_BURST) begin
          mdl_last = x; mdl_served = 0; mdl_owner = y;
        end else begin
          mdl_served = (mdl_served + 1 > MAX_BURST - 1) ? MAX_BURST - 1 : mdl_served + 1;
        end
      end
    end
  endtask

  // Entered and left 1 time unit after a rising edge; inputs are already driven.
  task automatic tick();
    #2;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic new_fields(input int i);
    m_addr[i]  = ADDR_W'($urandom);
    m_nbyte[i] = 4'($urandom);
    m_rnw[i]   = 1'($urandom);
    m_wdata[i] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; de_ack = 1'b0;
    m_req[0] = 1'b0; m_req[1] = 1'b0;
`ifdef DE_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          n0, n1;
    logic [19:0] pattern;
    logic [19:0] exp_pattern;
    rst = 1'b1; de_ack = 1'b0; de_r_data = 32'h0;
    for (int i = 0; i < 2; i++) begin m_req[i] = 1'b0; new_fields(i); end
`ifdef DE_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    mdl_owner = -1; mdl_last = 1; mdl_served = 0; mdl_stat[0] = 0; mdl_stat[1] = 0;
    @(posedge clk); #1;
    do_reset();

    // Single requester, three acks.
    m_req[0] = 1'b1; de_ack = 1'b1;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n0 += int'(obs_ack[0]); n1 += int'(obs_ack[1]);
    end
    check("t1_m0_acks", 32'(n0), 32'd3);
    check("t1_m1_acks", 32'(n1), 32'd0);

    // Contention with ack held high: four to port 0, four to port 1, then back.
    do_reset();
    m_req[0] = 1'b1; m_req[1] = 1'b1; de_ack = 1'b1;
    pattern = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      pattern = {pattern[17:0], obs_ack[1], obs_ack[0]};
    end
    exp_pattern = 20'b00_01_01_01_01_10_10_10_10_01;
    check("t2_grant_pattern", 32'(pattern), 32'(exp_pattern));

    // Owner releases after two acks while the other port waits.
    do_reset();
    m_req[0] = 1'b1; de_ack = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    m_req[0] = 1'b0; m_req[1] = 1'b1; m_addr[1] = 18'h2A5A5; de_ack = 1'b0;
    tick();
    #2;
    check("t3_m1_addr", 32'(de_addr), 32'h2A5A5);
    check("t3_busy", 32'(busy), 32'd1);
    #0 tick();

    // Port 1 alone, then contention after it releases: port 0 wins.
    do_reset();
    m_req[1] = 1'b1;
    tick(); tick();
    m_req[1] = 1'b0;
    tick();
    m_req[0] = 1'b1; m_req[1] = 1'b1; m_addr[0] = 18'h00123;
    tick();
    #2;
    check("t4_m0_wins", 32'(de_addr), 32'h00123);
    tick();

    // Reset in the middle of a port-1 burst.
    do_reset();
    m_req[1] = 1'b1; de_ack = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; m_req[0] = 1'b1; m_addr[0] = 18'h3BEEF; de_ack = 1'b0;
    #2;
    check("t5_req_after_rst", 32'(de_req), 32'd0);
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    tick();
    #2;
    check("t5_port0_first", 32'(de_addr), 32'h3BEEF);
    tick();

`ifdef DE_ARB_STATS_EN
    do_reset();
    m_req[0] = 1'b1; de_ack = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    m_req[0] = 1'b0; m_req[1] = 1'b1; de_ack = 1'b0;
    tick();
    de_ack = 1'b1;
    tick(); tick();
    de_ack = 1'b0;
    tick();
    check("t6_stat0", 32'(stat0), 32'd5);
    check("t6_stat1", 32'(stat1), 32'd2);
    m_req[1] = 1'b0; m_req[0] = 1'b1;
    tick(); tick();
    de_ack = 1'b1; stat_clr = 1'b1;
    tick();
    de_ack = 1'b0; stat_clr = 1'b0;
    tick();
    check("t6_clr_wins", 32'(stat0), 32'd0);
`endif

    // Randomized traffic: masters hold a request until acked, then continue or release.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (m_req[i]) begin
          if (exp_ack[i]) begin
            if ($urandom_range(3) == 0) m_req[i] = 1'b0;
            else new_fields(i);
          end
        end else if ($urandom_range(2) == 0) begin
          m_req[i] = 1'b1;
          new_fields(i);
        end
      end
      de_ack    = 1'($urandom_range(1));
      de_r_data = $urandom;
      rst       = ($urandom_range(199) == 0);
`ifdef DE_ARB_STATS_EN
      stat_clr  = ($urandom_range(99) == 0);
`endif
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
